multdiv_unit: RTL and testbench

- Iterative signed 32-bit multiply/divide unit.
- Sits directly downstream of the register file read ports: operands come from `data_readRegA`/`data_readRegB`, and the result goes back to the writeback path into `data_writeReg`.
- Multiply uses radix-2 Booth. Divide uses non-restoring division. Both take a fixed number of cycles.
- A one-cycle ready pulse tells the pipeline that `data_result`/`data_exception` may be written back.

---
 rtl/multdiv_unit.sv | 148 ++++++++++++++
 tb/tb_multdiv_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring) unit with a one-cycle ready pulse.
// Define MULTDIV_DIV_EN to build the divider; without it, a divide reports an exception after one cycle.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             ctrl_busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            accept, go_mul, go_div;

  // Booth register: one guard bit on the accumulator keeps A +/- M exact for the most-negative multiplicand
  logic [WIDTH-1:0] mcand, mq;
  logic [WIDTH:0]   acc, acc_sum;
  logic             q_m1;
  logic             mul_exc;

  // A strobe seen during the DONE cycle is taken on the edge that leaves DONE
  assign accept = (state == IDLE || state == DONE) && (ctrl_MULT || ctrl_DIV);
  assign go_mul = accept && ctrl_MULT;
  assign go_div = accept && !ctrl_MULT;

  assign ctrl_busy      = (state == MUL) || (state == DIV);
  assign data_resultRDY = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (go_mul)      state_nxt = MUL;
        else if (go_div) state_nxt = DIV;
        else             state_nxt = IDLE;
      end
      MUL: if (cnt == LAST) state_nxt = DONE;
`ifdef MULTDIV_DIV_EN
      DIV: if (cnt == LAST) state_nxt = DONE;
`else
      DIV: state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_sum = acc;
    case ({mq[0], q_m1})
      2'b01:   acc_sum = acc + {mcand[WIDTH-1], mcand};
      2'b10:   acc_sum = acc - {mcand[WIDTH-1], mcand};
      default: acc_sum = acc;
    endcase
  end

  // Product high word must be the sign extension of the low word
  assign mul_exc = acc[WIDTH-1:0] != {WIDTH{mq[WIDTH-1]}};

`ifdef MULTDIV_DIV_EN
  logic [WIDTH+1:0] rem, rem_shift, rem_nxt;
  logic [WIDTH-1:0] quo, dvs, quo_fix;
  logic             div_neg, div_zero, div_ovf;

  assign rem_shift = {rem[WIDTH:0], quo[WIDTH-1]};
  assign rem_nxt   = rem[WIDTH+1] ? rem_shift + {2'b00, dvs} : rem_shift - {2'b00, dvs};
  assign quo_fix   = div_neg ? -quo : quo;

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      div_neg  <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else if (go_div) begin
      rem      <= '0;
      quo      <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      dvs      <= data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
      div_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= data_operandB == '0;
      div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
    end else if (state == DIV && cnt != LAST) begin
      rem <= rem_nxt;
      quo <= {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
    end
  end
`endif

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      mcand          <= '0;
      mq             <= '0;
      acc            <= '0;
      q_m1           <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt            <= '0;
        data_result    <= '0;
        data_exception <= 1'b0;
        mcand          <= data_operandA;
        mq             <= data_operandB;
        acc            <= '0;
        q_m1           <= 1'b0;
      end else if (state == MUL) begin
        if (cnt != LAST) begin
          acc  <= {acc_sum[WIDTH], acc_sum[WIDTH:1]};
          mq   <= {acc_sum[0], mq[WIDTH-1:1]};
          q_m1 <= mq[0];
          cnt  <= cnt + CW'(1);
        end else begin
          data_result    <= mq;
          data_exception <= mul_exc;
        end
      end else if (state == DIV) begin
`ifdef MULTDIV_DIV_EN
        if (cnt != LAST) begin
          cnt <= cnt + CW'(1);
        end else begin
          data_result    <= div_zero ? '0 : quo_fix;
          data_exception <= div_zero | div_ovf;
        end
`else
        data_result    <= '0;
        data_exception <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized + directed bench for multdiv_unit against a cycle-level behavioural model.
module tb_multdiv_unit;

`ifdef MULTDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clock, ctrl_reset, ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic        data_exception, data_resultRDY, ctrl_busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .ctrl_busy(ctrl_busy)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // {exception, result} from plain signed arithmetic
  function automatic logic [32:0] ref_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [31:0] q;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {p != longint'($signed(p[31:0])), p[31:0]};
    end
    if (!DIV_EN || b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = 32'($signed(a) / $signed(b));
    return {1'b0, q};
  endfunction

  // Model: busy for a fixed count of edges after an accepted start, then one ready cycle
  bit          m_busy, m_rdy, m_exc;
  logic [31:0] m_res;
  logic [32:0] m_pend;
  int          m_left;

  always @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      m_busy <= 0; m_rdy <= 0; m_exc <= 0; m_res <= 0; m_pend <= 0; m_left <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 0;
        m_rdy  <= 1;
        {m_exc, m_res} <= m_pend;
      end
    end else begin
      m_rdy <= 0;
      if (ctrl_MULT || ctrl_DIV) begin
        m_busy <= 1;
        m_res  <= 0;
        m_exc  <= 0;
        m_pend <= ref_op(ctrl_MULT, data_operandA, data_operandB);
        m_left <= (ctrl_MULT || DIV_EN) ? 33 : 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy",   32'(ctrl_busy),      32'(m_busy));
      chk("rdy",    32'(data_resultRDY), 32'(m_rdy));
      chk("result", data_result,         m_res);
      chk("exc",    32'(data_exception), 32'(m_exc));
    end
  end

  // Issue one op, optionally inject a DIV 9/3 strobe inj cycles into it, check latency and literal result
  task automatic do_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input bit ee, input int inj, input string nm);
    int n, lat;
    bit got;
    logic [31:0] r_exp;
    bit e_exp;
    r_exp = er; e_exp = ee;
    if (!mul && !DIV_EN) begin r_exp = 0; e_exp = 1; end
    lat = (mul || DIV_EN) ? 33 : 1;
    @(negedge clock);
    ctrl_MULT = mul; ctrl_DIV = !mul; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 0; ctrl_DIV = 0;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (inj != 0 && n == inj) begin ctrl_DIV = 1; data_operandA = 9; data_operandB = 3; end
      if (inj != 0 && n == inj + 1) ctrl_DIV = 0;
      if (data_resultRDY) got = 1;
    end
    chk({nm, "_latency"}, 32'(n), 32'(lat));
    chk({nm, "_result"}, data_result, r_exp);
    chk({nm, "_exc"}, 32'(data_exception), 32'(e_exp));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb, rr;
    bit re, rm;
    ctrl_reset = 0; ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = 0; data_operandB = 0;
    #12;
    chk("reset_result", data_result, 32'h0);
    chk("reset_exc",    32'(data_exception), 32'h0);
    chk("reset_rdy",    32'(data_resultRDY), 32'h0);
    chk("reset_busy",   32'(ctrl_busy), 32'h0);
    @(negedge clock); ctrl_reset = 1; chk_en = 1;

    do_op(1, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 0, 0, "mul_basic");
    do_op(1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 0, "mul_ovf");
    do_op(1, 32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 0, 0, "mul_max");
    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "mul_min_neg1");
    do_op(1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 0, "mul_min_min");
    do_op(0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 0, "div_neg");
    do_op(0, 32'd100,       32'hFFFF_FFF6, 32'hFFFF_FFF6, 0, 0, "div_negb");
    do_op(0, 32'd5,         32'd7,         32'h0,         0, 0, "div_small");
    do_op(0, 32'd100,       32'd0,         32'h0,         1, 0, "div_zero");
    do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
    do_op(1, 32'd3,         32'd4,         32'd12,        0, 5, "start_busy");
    do_op(0, 32'd9,         32'd3,         32'd3,         0, 0, "div_after");

    // Reset in the middle of a multiply
    @(negedge clock);
    ctrl_MULT = 1; data_operandA = 3; data_operandB = 4;
    @(posedge clock); #1;
    ctrl_MULT = 0;
    repeat (10) @(posedge clock);
    #2 ctrl_reset = 0;
    #1;
    chk("midrst_result", data_result, 32'h0);
    chk("midrst_exc",    32'(data_exception), 32'h0);
    chk("midrst_rdy",    32'(data_resultRDY), 32'h0);
    chk("midrst_busy",   32'(ctrl_busy), 32'h0);
    @(negedge clock); @(negedge clock);
    ctrl_reset = 1;
    repeat (40) @(negedge clock);
    do_op(1, 32'd2, 32'd2, 32'd4, 0, 0, "mul_after_rst");

    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = pick();
      rb = pick();
      {re, rr} = ref_op(rm, ra, rb);
      do_op(rm, ra, rb, rr, re, 0, "rand");
    end

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
